// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, opcode encodings and op count.
package alu_pkg;

    localparam int unsigned ALU_XLEN    = 64;
    localparam int unsigned ALU_SHAMT_W = 6;
    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned ALU_NUM_OPS = 10;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: result, signed-overflow flag and illegal-op flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = ALU_XLEN,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     result,
    output logic                ovf,
    output logic                illegal
);

    logic [XLEN-1:0]    sum;
    logic [XLEN-1:0]    diff;
    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Opcode decode; undefined opcodes yield a zero result and raise illegal.
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 32'(op) >= ALU_NUM_OPS;
        case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage: one-entry valid/ready pipeline register around alu_core.
module exec_alu_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = ALU_XLEN,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [4:0]          in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [4:0]          out_rd,
    output logic                out_zero,
    output logic                out_ovf,
    output logic                out_illegal
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            load;
    logic [XLEN-1:0] core_result;
    logic            core_ovf;
    logic            core_illegal;

    alu_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_alu_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .result  (core_result),
        .ovf     (core_ovf),
        .illegal (core_illegal)
    );

    // Accept whenever the register is empty or is being drained this cycle.
    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign out_valid = (state_q == ST_FULL);

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and load enable from the two handshakes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result and status registers; they keep their value when not loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_rd      <= '0;
            out_zero    <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (load) begin
            out_result  <= core_result;
            out_rd      <= in_rd;
            out_zero    <= (core_result == '0);
            out_ovf     <= core_ovf;
            out_illegal <= core_illegal;
        end
    end

endmodule
